// File: rtl/controle.sv
`default_nettype none
// ============================================================================
// Module   : controle
// Moore sequencer driving the operativo datapath (LOADX, OP1-OP4, DONE).
// Build option: CONTROLE_HANDSHAKE_EN keeps DONE asserted while inicio is high.
// Revision : 1.0
// ============================================================================
module controle (
    input  logic       ck,
    input  logic       rst,
    input  logic       inicio,
    input  logic       modo,
    output logic       lx,
    output logic [1:0] m0,
    output logic [1:0] m1,
    output logic [1:0] m2,
    output logic       h,
    output logic       ls,
    output logic       lh,
    output logic       pronto
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADX = 3'd1,
        S_OP1   = 3'd2,
        S_OP2   = 3'd3,
        S_OP3   = 3'd4,
        S_OP4   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   modo_q,  modo_d;

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q <= S_IDLE;
            modo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            modo_q  <= modo_d;
        end
    end

    // modo is captured only when a run is accepted
    always_comb begin
        state_d = state_q;
        modo_d  = modo_q;
        case (state_q)
            S_IDLE: begin
                if (inicio) begin
                    state_d = S_LOADX;
                    modo_d  = modo;
                end
            end
            S_LOADX: state_d = S_OP1;
            S_OP1:   state_d = S_OP2;
            S_OP2:   state_d = S_OP3;
            S_OP3:   state_d = S_OP4;
            S_OP4:   state_d = S_DONE;
            S_DONE: begin
`ifdef CONTROLE_HANDSHAKE_EN
                state_d = inicio ? S_DONE : S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lx     = 1'b0;
        m0     = 2'b00;
        m1     = 2'b00;
        m2     = 2'b00;
        h      = 1'b0;
        ls     = 1'b0;
        lh     = 1'b0;
        pronto = 1'b0;
        case (state_q)
            S_LOADX: lx = 1'b1;
            S_OP1: begin
                m0 = 2'b01;
                if (modo_q) begin
                    lh = 1'b1;
                end else begin
                    h  = 1'b1;
                    ls = 1'b1;
                end
            end
            S_OP2: begin
                m0 = 2'b10;
                ls = 1'b1;
                if (!modo_q) begin
                    m1 = 2'b10;
                    m2 = 2'b01;
                end
            end
            S_OP3: begin
                m1 = 2'b10;
                m2 = modo_q ? 2'b11 : 2'b00;
                h  = 1'b1;
                ls = 1'b1;
            end
            S_OP4: begin
                m0 = 2'b11;
                m1 = 2'b10;
                m2 = 2'b01;
                ls = 1'b1;
            end
            S_DONE:  pronto = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_controle.sv
`default_nettype none
// Bench for controle: per-cycle control-word check plus a behavioural datapath
// whose final RegS is compared against the closed-form polynomial.
module tb_controle;

    logic       ck = 1'b0;
    logic       rst = 1'b0;
    logic       inicio = 1'b0;
    logic       modo = 1'b0;
    logic       lx, h, ls, lh, pronto;
    logic [1:0] m0, m1, m2;

    logic [15:0] x_in = '0, a_in = '0, b_in = '0, c_in = '0;
    int          tests = 0;
    int          fails = 0;

    int          phase = 0;
    int          prev_phase = 0;
    logic        mode_m = 1'b0;
    logic [15:0] rx = '0, rs = '0, rh = '0;
    logic [15:0] ox = '0, oa = '0, ob = '0, oc = '0;
    logic        omode = 1'b0;

    controle dut (
        .ck     (ck),
        .rst    (rst),
        .inicio (inicio),
        .modo   (modo),
        .lx     (lx),
        .m0     (m0),
        .m1     (m1),
        .m2     (m2),
        .h      (h),
        .ls     (ls),
        .lh     (lh),
        .pronto (pronto)
    );

    always #5 ck = ~ck;

    // {lx, m0, m1, m2, h, ls, lh, pronto} for a given step of a run
    function automatic logic [10:0] exp_out(int ph, logic md);
        case (ph)
            1:       return 11'b1_00_00_00_0_0_0_0;
            2:       return md ? 11'b0_01_00_00_0_0_1_0 : 11'b0_01_00_00_1_1_0_0;
            3:       return md ? 11'b0_10_00_00_0_1_0_0 : 11'b0_10_10_01_0_1_0_0;
            4:       return md ? 11'b0_00_10_11_1_1_0_0 : 11'b0_00_10_00_1_1_0_0;
            5:       return 11'b0_11_10_01_0_1_0_0;
            6:       return 11'b0_00_00_00_0_0_0_1;
            default: return 11'b0;
        endcase
    endfunction

    function automatic logic [15:0] formula(logic md, logic [15:0] x, a, b, c);
        logic [15:0] t;
        if (!md) begin
            t = a * x;
            t = t + b;
            t = t * x;
        end else begin
            t = (a + x) * (b + x);
        end
        return t + c;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (phase %0d)", tag, obs, expv, phase);
        end
    endtask

    // One clock: advance the reference model and datapath, then check the DUT.
    task automatic cycle();
        logic [15:0] v0, l, r, alu;
        logic        p_lx, p_ls, p_lh;
        int          nph;
        logic        nmode;
        case (m0)
            2'b01:   v0 = a_in;
            2'b10:   v0 = b_in;
            2'b11:   v0 = c_in;
            default: v0 = 16'd0;
        endcase
        case (m1)
            2'b01:   l = rx;
            2'b10:   l = rs;
            2'b11:   l = rh;
            default: l = v0;
        endcase
        case (m2)
            2'b01:   r = v0;
            2'b10:   r = rs;
            2'b11:   r = rh;
            default: r = rx;
        endcase
        alu  = h ? l * r : l + r;
        p_lx = lx;
        p_ls = ls;
        p_lh = lh;

        nph   = phase;
        nmode = mode_m;
        if (!rst) begin
            nph   = 0;
            nmode = 1'b0;
        end else begin
            case (phase)
                0: if (inicio) begin
                    nph   = 1;
                    nmode = modo;
                end
                1: begin
                    nph = 2;
                    ox = x_in; oa = a_in; ob = b_in; oc = c_in; omode = mode_m;
                end
`ifdef CONTROLE_HANDSHAKE_EN
                6: nph = inicio ? 6 : 0;
`else
                6: nph = 0;
`endif
                default: nph = phase + 1;
            endcase
        end

        @(posedge ck);
        if (!rst) begin
            rx = '0; rs = '0; rh = '0;
        end else begin
            if (p_lx === 1'b1) rx = x_in;
            if (p_ls === 1'b1) rs = alu;
            if (p_lh === 1'b1) rh = alu;
        end
        prev_phase = phase;
        phase      = nph;
        mode_m     = nmode;
        #1;
        check("ctrl", {5'd0, lx, m0, m1, m2, h, ls, lh, pronto}, {5'd0, exp_out(phase, mode_m)});
        if (phase == 6 && prev_phase == 5)
            check("resultado", rs, formula(omode, ox, oa, ob, oc));
    endtask

    task automatic run(logic md, logic [15:0] x, a, b, c);
        modo = md; x_in = x; a_in = a; b_in = b; c_in = c;
        inicio = 1'b1;
        cycle();
        inicio = 1'b0;
        modo   = ~md;
        repeat (7) cycle();
    endtask

    initial begin
        int   rises;
        logic prev_p;

        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();

        run(1'b0, 16'd2, 16'd3, 16'd4, 16'd5);
        check("mode0_y", rs, 16'd25);
        run(1'b1, 16'd2, 16'd1, 16'd3, 16'd4);
        check("mode1_y", rs, 16'd19);
        run(1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000);

        // abandon a run during OP2
        modo = 1'b1; inicio = 1'b1;
        cycle();
        inicio = 1'b0;
        repeat (2) cycle();
        check("at_op2", {15'd0, ls}, 16'd1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (3) cycle();
        run(1'b0, 16'd7, 16'd11, 16'd13, 16'd17);

        // back-to-back requests with modo toggling underneath
        x_in = 16'($urandom); a_in = 16'($urandom); b_in = 16'($urandom); c_in = 16'($urandom);
        inicio = 1'b1;
        rises  = 0;
        prev_p = 1'b0;
`ifdef CONTROLE_HANDSHAKE_EN
        repeat (10) begin
            modo = 1'($urandom);
            cycle();
            if (pronto && !prev_p) rises++;
            prev_p = pronto;
        end
        inicio = 1'b0;
        repeat (3) begin
            cycle();
            if (pronto && !prev_p) rises++;
            prev_p = pronto;
        end
        check("hs_runs", 16'(rises), 16'd1);
`else
        repeat (21) begin
            modo = 1'($urandom);
            cycle();
            if (pronto && !prev_p) rises++;
            prev_p = pronto;
        end
        inicio = 1'b0;
        check("b2b_runs", 16'(rises), 16'd3);
`endif
        repeat (2) cycle();

        // random traffic, operands only change while no run is using them
        repeat (400) begin
            if (phase == 0 || phase == 6) begin
                x_in = 16'($urandom); a_in = 16'($urandom);
                b_in = 16'($urandom); c_in = 16'($urandom);
            end
            inicio = 1'($urandom);
            modo   = 1'($urandom);
            rst    = ($urandom_range(0, 49) != 0);
            cycle();
        end
        rst = 1'b1;
        inicio = 1'b0;
        repeat (9) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
